sgt_share_arbiter: RTL and testbench
====================================

Name: sgt_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one signed subtract/compare datapath (`A − B` plus signed greater-than) among N requesters.
- Each requester presents a signed operand pair with a valid/ready handshake.
- The arbiter grants one pair per cycle, registers the difference, overflow and greater-than result, and returns them on a single response channel tagged with the requester ID.
- Sits between control engines (sort/max/threshold units) and the single compare datapath, so only one subtractor carry chain is instantiated.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits, two's-complement signed.
- IDW, clog2(N), width of the requester ID field.

Ports:
- CLK  input  1  rising-edge clock.
- ASYNCRESETN  input  1  reset, asynchronous assert, active-low; deassert is synchronous to CLK upstream.
- REQ_VALID  input  N  per-requester request valid.
- REQ_READY  output  N  per-requester grant/accept, one-hot or zero.
- REQ_A  input  N*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_B  input  N*WIDTH  operand B, same packing.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  response consumer ready.
- RSP_ID  output  IDW  index of the requester that owns the response.
- RSP_DIFF  output  WIDTH  A − B modulo 2^WIDTH.
- RSP_OVF  output  1  signed overflow of A − B.
- RSP_GT  output  1  1 when A > B as signed values.

Behaviour:
- Reset (ASYNCRESETN=0): takes effect immediately, independent of CLK.
  - RSP_VALID=0, RSP_ID=0, RSP_DIFF=0, RSP_OVF=0, RSP_GT=0.
  - Round-robin pointer PTR=0.
  - REQ_READY=0 while reset is held.
  - Reset mid-transaction discards the held response; nothing is replayed.
- Accept enable: ACC = !RSP_VALID || RSP_READY (output slot empty, or being drained this cycle).
- Grant:
  - G = first index i scanning PTR, PTR+1, …, N−1, 0, …, PTR−1 with REQ_VALID[i]=1.
  - REQ_READY[G]=1 only when ACC=1 and at least one REQ_VALID is set; all other REQ_READY bits are 0.
  - REQ_READY is combinational from REQ_VALID, PTR and the RSP state.
- Transfer: occurs on the clock edge where REQ_VALID[G] && REQ_READY[G]. On that edge:
  - RSP_VALID←1, RSP_ID←G.
  - RSP_DIFF←A_G − B_G, truncated to WIDTH.
  - RSP_OVF←(A_G[msb] != B_G[msb]) && (DIFF[msb] != A_G[msb]).
  - RSP_GT←(A_G > B_G) signed; equivalently computed from B − A sign XOR its overflow, and exactly 0 when A == B.
  - PTR←(G+1) mod N.
- Drain: if RSP_VALID && RSP_READY and no transfer on the same edge, RSP_VALID←0. The data fields hold their last values.
- Back-to-back: drain and new transfer on the same edge are allowed, giving one response per cycle at full throughput.
- Backpressure: while RSP_VALID=1 and RSP_READY=0:
  - all REQ_READY=0;
  - RSP_* hold stable;
  - PTR holds.
- Latency: request accepted at edge t → RSP_VALID=1 visible after edge t, i.e. one cycle.
- Requester rules: REQ_VALID, once asserted, and its operands must stay stable until the accepting edge. The arbiter does not check this.
- Idle (no REQ_VALID): PTR holds; no responses are generated.
- Fairness: any continuously asserted request is granted within N accepts.
- State: PTR plus the response register only. The FSM has two states, EMPTY (RSP_VALID=0) and FULL (RSP_VALID=1):
  - EMPTY→FULL on transfer;
  - FULL→EMPTY on drain without transfer;
  - FULL→FULL on drain with transfer, or on stall.

Test Plan (N=4, WIDTH=4):
- Async reset: assert ASYNCRESETN=0 between edges while RSP_VALID=1 → RSP_VALID, RSP_* and REQ_READY go to 0 before the next edge; after release, PTR=0, so simultaneous requests 0 and 2 grant 0 first.
- Single request: requester 1, A=3, B=4'hE (−2), RSP_READY=1 → REQ_READY=4'b0010 in that cycle; next cycle RSP_VALID=1, RSP_ID=1, RSP_DIFF=5, RSP_OVF=0, RSP_GT=1.
- Overflow and equality:
  - A=7, B=−1 → DIFF=4'h8, OVF=1, GT=1.
  - A=−8, B=1 → DIFF=7, OVF=1, GT=0.
  - A=B=−3 → DIFF=0, OVF=0, GT=0.
- Round-robin: all four REQ_VALID held high, RSP_READY=1 → grants 0,1,2,3,0 on consecutive cycles with one response per cycle. With only requesters 0 and 3 valid after a grant to 2 → next grant is 3, then 0.
- Backpressure: after one response, RSP_READY=0 for 3 cycles with requests pending → REQ_READY=0 and RSP_* stable for all 3 cycles. Raise RSP_READY → drain and the next grant happen on the same edge, with no bubble.
- Random soak: random REQ_VALID and RSP_READY over 10k cycles, checked by a scoreboard:
  - every request is answered exactly once, in grant order;
  - no requester waits more than 4 accepts;
  - results match a signed reference model.

Source files
------------

// File: rtl/sgt_share_arbiter.sv
// sgt_share_arbiter: round-robin arbiter sharing one signed subtract/compare datapath among N requesters
module sgt_share_arbiter #(
  parameter int N = 4,
  parameter int WIDTH = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         REQ_VALID,
  output logic [N-1:0]         REQ_READY,
  input  logic [N*WIDTH-1:0]   REQ_A,
  input  logic [N*WIDTH-1:0]   REQ_B,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [IDW-1:0]       RSP_ID,
  output logic [WIDTH-1:0]     RSP_DIFF,
  output logic                 RSP_OVF,
  output logic                 RSP_GT
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt;
  logic [WIDTH-1:0] diff_q, diff_d, a, b, diff;
  logic ovf_q, ovf_d, gt_q, gt_d, xfer;
  always_comb begin
    gnt = ptr_q;
    // scan downward so the lowest offset from ptr_q wins
    for (int k = N - 1; k >= 0; k--)
      if (REQ_VALID[(int'(ptr_q) + k) % N]) gnt = IDW'((int'(ptr_q) + k) % N);
    xfer = ASYNCRESETN && (|REQ_VALID) && (state_q == EMPTY || RSP_READY);
    REQ_READY = '0;
    REQ_READY[gnt] = xfer;
    a = REQ_A[int'(gnt)*WIDTH +: WIDTH];
    b = REQ_B[int'(gnt)*WIDTH +: WIDTH];
    diff = a - b;
    state_d = xfer ? FULL : (RSP_READY ? EMPTY : state_q);
    id_d = xfer ? gnt : id_q;
    diff_d = xfer ? diff : diff_q;
    ovf_d = xfer ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : ovf_q;
    gt_d = xfer ? ($signed(a) > $signed(b)) : gt_q;
    ptr_d = xfer ? ((int'(gnt) == N - 1) ? '0 : gnt + 1'b1) : ptr_q;
  end
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      id_q <= '0;
      diff_q <= '0;
      ovf_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      diff_q <= diff_d;
      ovf_q <= ovf_d;
      gt_q <= gt_d;
    end
  end
  assign RSP_VALID = (state_q == FULL);
  assign RSP_ID = id_q;
  assign RSP_DIFF = diff_q;
  assign RSP_OVF = ovf_q;
  assign RSP_GT = gt_q;
endmodule

// File: tb/tb_sgt_share_arbiter.sv
// tb_sgt_share_arbiter: directed and randomized checks of sgt_share_arbiter against an arithmetic reference model
module tb_sgt_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  logic [N-1:0] REQ_VALID = '0;
  logic [N-1:0] REQ_READY;
  logic [N*W-1:0] REQ_A = '0;
  logic [N*W-1:0] REQ_B = '0;
  logic RSP_VALID;
  logic RSP_READY = 1'b0;
  logic [1:0] RSP_ID;
  logic [W-1:0] RSP_DIFF;
  logic RSP_OVF, RSP_GT;

  sgt_share_arbiter #(.N(N), .WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DIFF(RSP_DIFF), .RSP_OVF(RSP_OVF), .RSP_GT(RSP_GT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { int id; int a; int b; } txn_t;
  txn_t sbq[$];
  int ptr, mid, mdiff, movf, mgt, last_g;
  bit mv;
  int waits [N];
  logic [31:0] s_ready, s_valid, s_id, s_diff, s_ovf, s_gt;

  function automatic int sx(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  task automatic model_reset();
    ptr = 0; mv = 0; mid = 0; mdiff = 0; movf = 0; mgt = 0; last_g = -1;
    sbq.delete();
    for (int i = 0; i < N; i++) waits[i] = 0;
  endtask

  task automatic cyc();
    int g, a, b, d;
    bit acc, drained;
    txn_t t;
    @(negedge CLK);
    acc = !mv || RSP_READY;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && REQ_VALID[(ptr + k) % N]) g = (ptr + k) % N;
    s_ready = 32'(REQ_READY); s_valid = 32'(RSP_VALID); s_id = 32'(RSP_ID);
    s_diff = 32'(RSP_DIFF); s_ovf = 32'(RSP_OVF); s_gt = 32'(RSP_GT);
    chk("req_ready", s_ready, (acc && g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rsp_valid", s_valid, 32'(mv));
    chk("rsp_id", s_id, 32'(mid));
    chk("rsp_diff", s_diff, 32'(mdiff));
    chk("rsp_ovf", s_ovf, 32'(movf));
    chk("rsp_gt", s_gt, 32'(mgt));
    @(posedge CLK);
    drained = mv && RSP_READY;
    if (drained) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        t = sbq.pop_front();
        d = t.a - t.b;
        chk("sb_id", s_id, 32'(t.id));
        chk("sb_diff", s_diff, 32'(d & 15));
      end
    end
    last_g = -1;
    if (acc && g >= 0) begin
      a = sx(REQ_A[g*W +: W]);
      b = sx(REQ_B[g*W +: W]);
      d = a - b;
      sbq.push_back('{g, a, b});
      mv = 1; mid = g; mdiff = d & 15; movf = (d > 7 || d < -8); mgt = (a > b);
      ptr = (g + 1) % N;
      chk("fairness", 32'(waits[g] < N), 32'd1);
      for (int i = 0; i < N; i++) if (REQ_VALID[i] && i != g) waits[i]++;
      waits[g] = 0;
      last_g = g;
    end else if (drained) mv = 0;
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    REQ_A[i*W +: W] = a;
    REQ_B[i*W +: W] = b;
  endtask

  task automatic one(input int i, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] ed, input bit eo, input bit eg);
    set_op(i, a, b);
    REQ_VALID = 4'(1 << i);
    RSP_READY = 1'b1;
    cyc();
    REQ_VALID = '0;
    cyc();
    chk("vec_diff", s_diff, 32'(ed));
    chk("vec_ovf", s_ovf, 32'(eo));
    chk("vec_gt", s_gt, 32'(eg));
  endtask

  initial begin
    logic [3:0] order [5];
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valid", 32'(RSP_VALID), 32'd0);
    chk("reset_ready", 32'(REQ_READY), 32'd0);
    #3 ASYNCRESETN = 1'b1;
    // single request
    set_op(1, 4'd3, 4'hE);
    REQ_VALID = 4'b0010;
    RSP_READY = 1'b1;
    cyc();
    chk("single_ready", s_ready, 32'b0010);
    REQ_VALID = '0;
    cyc();
    chk("single_valid", s_valid, 32'd1);
    chk("single_id", s_id, 32'd1);
    chk("single_diff", s_diff, 32'd5);
    chk("single_ovf", s_ovf, 32'd0);
    chk("single_gt", s_gt, 32'd1);
    // overflow and equality corners
    one(2, 4'd7, 4'hF, 4'h8, 1'b1, 1'b1);
    one(2, 4'h8, 4'd1, 4'h7, 1'b1, 1'b0);
    one(2, 4'hD, 4'hD, 4'h0, 1'b0, 1'b0);
    // async reset while a response is held
    set_op(0, 4'd1, 4'd2);
    set_op(2, 4'd5, 4'd1);
    REQ_VALID = 4'b0001;
    RSP_READY = 1'b0;
    cyc();
    REQ_VALID = 4'b0101;
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("areset_valid", 32'(RSP_VALID), 32'd0);
    chk("areset_diff", 32'(RSP_DIFF), 32'd0);
    chk("areset_id", 32'(RSP_ID), 32'd0);
    chk("areset_ready", 32'(REQ_READY), 32'd0);
    model_reset();
    ASYNCRESETN = 1'b1;
    RSP_READY = 1'b1;
    cyc();
    chk("after_reset_grant", s_ready, 32'b0001);
    // round robin: ptr is now 1; run to full rotation then 0,1,2,3,0 pattern
    for (int i = 0; i < N; i++) set_op(i, 4'(i + 2), 4'(i));
    REQ_VALID = 4'b1111;
    order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_grant", s_ready, 32'(order[i]));
      if (i > 0) chk("rr_rsp_valid", s_valid, 32'd1);
    end
    cyc();
    chk("rr_grant2", s_ready, 32'b0100);
    REQ_VALID = 4'b1001;
    cyc();
    chk("rr_skip_to3", s_ready, 32'b1000);
    REQ_VALID = 4'b0001;
    cyc();
    chk("rr_wrap_to0", s_ready, 32'b0001);
    // backpressure
    REQ_VALID = 4'b1111;
    RSP_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_ready", s_ready, 32'd0);
      chk("bp_valid", s_valid, 32'd1);
    end
    RSP_READY = 1'b1;
    cyc();
    chk("bp_release_grant", s_ready, 32'b0010);
    cyc();
    chk("bp_next_id", s_id, 32'd1);
    // random soak
    REQ_VALID = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (REQ_VALID[i] && last_g == i) REQ_VALID[i] = 1'b0;
        if (!REQ_VALID[i] && $urandom_range(0, 2) == 0) begin
          REQ_VALID[i] = 1'b1;
          set_op(i, 4'($urandom), 4'($urandom));
        end
      end
      RSP_READY = ($urandom_range(0, 3) != 0);
      cyc();
    end
    REQ_VALID = '0;
    RSP_READY = 1'b1;
    cyc();
    cyc();
    chk("sb_all_answered", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
